// File: rtl/simon_key_expander.sv
// Simon key-schedule engine: expands a 2/3/4-word master key into T round keys
// and stores them in one of KEY_SLOTS buffers, readable with a fixed 2-cycle latency.
module simon_key_expander #(
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned KEY_SLOTS = 2,
    parameter int unsigned SLOT_W    = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_start,
    output logic                        key_ready,
    input  logic [1:0]                  key_mode,
    input  logic [SLOT_W-1:0]           key_slot,
    input  logic [4*WORD_W-1:0]         init_key,
    output logic                        key_cfg_err,
    output logic                        key_done,
    output logic [KEY_SLOTS-1:0]        slot_valid,
    output logic [7*KEY_SLOTS-1:0]      slot_rounds,
    input  logic                        key_rd_en,
    input  logic [SLOT_W-1:0]           key_rd_slot,
    input  logic [6:0]                  key_rd_addr,
    output logic [WORD_W-1:0]           key_data,
    output logic                        key_data_vld,
    output logic                        key_rd_err
);

    localparam int unsigned RND_W = 7;
    localparam int unsigned DEPTH = KEY_SLOTS * 128;
    localparam logic [WORD_W-1:0] C_CONST = ~WORD_W'(3);
    // z2, z3, z4; leftmost character of each sequence is round 0 (bit 61)
    localparam logic [61:0] Z_TAB [3] = '{
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    if (WORD_W != 32 && WORD_W != 48 && WORD_W != 64) begin : g_bad_word
        $error("simon_key_expander: WORD_W must be 32, 48 or 64");
    end
    if (KEY_SLOTS < 1 || (KEY_SLOTS & (KEY_SLOTS - 1)) != 0) begin : g_bad_slots
        $error("simon_key_expander: KEY_SLOTS must be a power of two");
    end

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state, state_nx;
    logic                accept, cfg_bad, step, last;
    logic                cfg_legal;
    logic [RND_W-1:0]    cfg_rounds;
    logic [1:0]          cfg_zsel;

    logic [WORD_W-1:0]   key_r [4];
    logic [1:0]          m_r;
    logic [1:0]          zsel_r;
    logic [RND_W-1:0]    t_r;
    logic [RND_W-1:0]    round_r;
    logic [5:0]          z_idx_r;
    logic [SLOT_W-1:0]   slot_r;

    logic [WORD_W-1:0]   k_last, tmp, k_new;
    logic                z_bit;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   mem_q;
    logic                s1_en, s1_err;
    logic                rd_err_c;

    // legal (WORD_W, m) pairs with their round count and z sequence
    always_comb begin
        cfg_legal  = 1'b0;
        cfg_rounds = '0;
        cfg_zsel   = '0;
        if (WORD_W == 32) begin
            case (key_mode)
                2'd1:    begin cfg_legal = 1'b1; cfg_rounds = 7'd42; cfg_zsel = 2'd0; end
                2'd2:    begin cfg_legal = 1'b1; cfg_rounds = 7'd44; cfg_zsel = 2'd1; end
                default: ;
            endcase
        end else if (WORD_W == 48) begin
            case (key_mode)
                2'd0:    begin cfg_legal = 1'b1; cfg_rounds = 7'd52; cfg_zsel = 2'd0; end
                2'd1:    begin cfg_legal = 1'b1; cfg_rounds = 7'd54; cfg_zsel = 2'd1; end
                default: ;
            endcase
        end else begin
            case (key_mode)
                2'd0:    begin cfg_legal = 1'b1; cfg_rounds = 7'd68; cfg_zsel = 2'd0; end
                2'd1:    begin cfg_legal = 1'b1; cfg_rounds = 7'd69; cfg_zsel = 2'd1; end
                2'd2:    begin cfg_legal = 1'b1; cfg_rounds = 7'd72; cfg_zsel = 2'd2; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cfg_bad  = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_start) begin
                    if (cfg_legal) begin
                        accept   = 1'b1;
                        state_nx = ST_RUN;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (round_r == 7'(t_r - 7'd1)) begin
                    last     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // next key word from the current m-word window
    always_comb begin
        k_last = key_r[m_r + 2'd1];
        tmp    = {k_last[2:0], k_last[WORD_W-1:3]} ^ ((m_r == 2'd2) ? key_r[1] : '0);
        z_bit  = Z_TAB[zsel_r][6'd61 - z_idx_r];
        k_new  = C_CONST ^ WORD_W'(z_bit) ^ key_r[0] ^ tmp ^ {tmp[0], tmp[WORD_W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ready   <= 1'b1;
            key_done    <= 1'b0;
            key_cfg_err <= 1'b0;
            slot_valid  <= '0;
            slot_rounds <= '0;
            for (int j = 0; j < 4; j++) key_r[j] <= '0;
            m_r         <= '0;
            zsel_r      <= '0;
            t_r         <= '0;
            round_r     <= '0;
            z_idx_r     <= '0;
            slot_r      <= '0;
        end else begin
            key_ready   <= (state_nx == ST_IDLE);
            key_done    <= last;
            key_cfg_err <= cfg_bad;
            if (accept) begin
                for (int j = 0; j < 4; j++) key_r[j] <= init_key[j*WORD_W +: WORD_W];
                m_r                  <= key_mode;
                zsel_r               <= cfg_zsel;
                t_r                  <= cfg_rounds;
                round_r              <= '0;
                z_idx_r              <= '0;
                slot_r               <= key_slot;
                slot_valid[key_slot] <= 1'b0;
            end else if (step) begin
                for (int j = 0; j < 3; j++) key_r[j] <= key_r[j+1];
                key_r[m_r + 2'd1] <= k_new;
                round_r <= round_r + 7'd1;
                z_idx_r <= (z_idx_r == 6'd61) ? 6'd0 : z_idx_r + 6'd1;
            end
            if (last) begin
                slot_valid[slot_r]                    <= 1'b1;
                slot_rounds[slot_r*RND_W +: RND_W]    <= t_r;
            end
        end
    end

    // round-key storage: engine write port, free-running read port
    always_ff @(posedge clk) begin
        if (step) mem[{slot_r, round_r}] <= key_r[0];
        mem_q <= mem[{key_rd_slot, key_rd_addr}];
    end

    assign rd_err_c = !slot_valid[key_rd_slot] ||
                      (key_rd_addr >= slot_rounds[key_rd_slot*RND_W +: RND_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_en        <= 1'b0;
            s1_err       <= 1'b0;
            key_data_vld <= 1'b0;
            key_rd_err   <= 1'b0;
            key_data     <= '0;
        end else begin
            s1_en        <= key_rd_en;
            s1_err       <= rd_err_c;
            key_data_vld <= s1_en;
            key_rd_err   <= s1_en & s1_err;
            if (s1_en) key_data <= s1_err ? '0 : mem_q;
        end
    end

endmodule

// File: tb/tb_simon_key_expander.sv
// Bench for simon_key_expander: 64-bit and 32-bit builds driven from one sequence,
// round keys checked against a straightforward Simon key-schedule model.
module tb_simon_key_expander;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, key_start, sel32, key_slot, key_rd_en, key_rd_slot;
    logic [1:0]   key_mode;
    logic [255:0] init_key;
    logic [6:0]   key_rd_addr;
    logic [127:0] init32;
    logic         start64, start32;

    logic         ready64, cfg64, done64, vld64, err64;
    logic [1:0]   sv64;
    logic [13:0]  sr64;
    logic [63:0]  d64;
    logic         ready32, cfg32, done32, vld32, err32;
    logic [1:0]   sv32;
    logic [13:0]  sr32;
    logic [31:0]  d32;

    assign init32  = {init_key[223:192], init_key[159:128], init_key[95:64], init_key[31:0]};
    assign start64 = key_start & ~sel32;
    assign start32 = key_start & sel32;

    simon_key_expander #(.WORD_W(64), .KEY_SLOTS(2)) u_dut (
        .clk(clk), .rst(rst), .key_start(start64), .key_ready(ready64), .key_mode(key_mode),
        .key_slot(key_slot), .init_key(init_key), .key_cfg_err(cfg64), .key_done(done64),
        .slot_valid(sv64), .slot_rounds(sr64), .key_rd_en(key_rd_en), .key_rd_slot(key_rd_slot),
        .key_rd_addr(key_rd_addr), .key_data(d64), .key_data_vld(vld64), .key_rd_err(err64)
    );

    simon_key_expander #(.WORD_W(32), .KEY_SLOTS(2)) u_dut32 (
        .clk(clk), .rst(rst), .key_start(start32), .key_ready(ready32), .key_mode(key_mode),
        .key_slot(key_slot), .init_key(init32), .key_cfg_err(cfg32), .key_done(done32),
        .slot_valid(sv32), .slot_rounds(sr32), .key_rd_en(key_rd_en), .key_rd_slot(key_rd_slot),
        .key_rd_addr(key_rd_addr), .key_data(d32), .key_data_vld(vld32), .key_rd_err(err32)
    );

    logic        obs_ready, obs_cfg_err, obs_done, obs_vld, obs_rd_err;
    logic [1:0]  obs_slot_valid;
    logic [13:0] obs_slot_rounds;
    logic [63:0] obs_data;
    assign obs_ready       = sel32 ? ready32 : ready64;
    assign obs_cfg_err     = sel32 ? cfg32   : cfg64;
    assign obs_done        = sel32 ? done32  : done64;
    assign obs_vld         = sel32 ? vld32   : vld64;
    assign obs_rd_err      = sel32 ? err32   : err64;
    assign obs_slot_valid  = sel32 ? sv32    : sv64;
    assign obs_slot_rounds = sel32 ? sr32    : sr64;
    assign obs_data        = sel32 ? {32'd0, d32} : d64;

    localparam logic [255:0] TV_KEY = {64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
                                       64'h0f0e0d0c0b0a0908, 64'h0706050403020100};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          cfg_cnt  = 0;
    bit          m_valid [2];
    int          m_t     [2];
    logic [63:0] m_sched [2][128];
    logic [63:0] exp_sched [128];
    bit          e_v   [2];
    bit          e_err [2];
    logic [63:0] e_dat [2];
    logic [63:0] last_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string zseq(input int idx);
        case (idx)
            2:       return "10101111011100000011010010011000101000010001111110010110110011";
            3:       return "11011011101011000110010111100000010010001010011100110100001111";
            default: return "11010001111001101011011000100000010111000011001010010011101111";
        endcase
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int s, input int n,
                                        input logic [63:0] mask);
        return ((x >> s) | (x << (n - s))) & mask;
    endfunction

    // Simon key schedule from the published round rules; t=0 means illegal pair
    task automatic build(input int n, input int m, input logic [255:0] key, output int t);
        int          zi;
        string       zs;
        logic [63:0] mask, tmp, zb;
        t = 0; zi = 0;
        if      (n == 32 && m == 3) begin t = 42; zi = 2; end
        else if (n == 32 && m == 4) begin t = 44; zi = 3; end
        else if (n == 48 && m == 2) begin t = 52; zi = 2; end
        else if (n == 48 && m == 3) begin t = 54; zi = 3; end
        else if (n == 64 && m == 2) begin t = 68; zi = 2; end
        else if (n == 64 && m == 3) begin t = 69; zi = 3; end
        else if (n == 64 && m == 4) begin t = 72; zi = 4; end
        if (t == 0) return;
        zs   = zseq(zi);
        mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) exp_sched[i] = key[i*64 +: 64] & mask;
        for (int i = m; i < t; i++) begin
            tmp = ror(exp_sched[i-1], 3, n, mask);
            if (m == 4) tmp = tmp ^ exp_sched[i-3];
            tmp = tmp ^ ror(tmp, 1, n, mask);
            zb  = (zs[(i - m) % 62] == "1") ? 64'd1 : 64'd0;
            exp_sched[i] = (~exp_sched[i-m] ^ tmp ^ zb ^ 64'd3) & mask;
        end
    endtask

    // advance one cycle and check whatever read result is due now
    task automatic tick();
        @(negedge clk);
        chk("rd_vld", obs_vld, e_v[1]);
        if (e_v[1]) begin
            chk("rd_err", obs_rd_err, e_err[1]);
            chk("rd_data", obs_data, e_dat[1]);
            last_data = e_dat[1];
        end else begin
            chk("rd_err_idle", obs_rd_err, 0);
            chk("rd_hold", obs_data, last_data);
        end
        if (obs_done)    done_cnt++;
        if (obs_cfg_err) cfg_cnt++;
        e_v[1] = e_v[0]; e_err[1] = e_err[0]; e_dat[1] = e_dat[0];
        e_v[0] = 1'b0;
        key_rd_en = 1'b0;
    endtask

    task automatic rd(input int slot, input int addr);
        key_rd_en   = 1'b1;
        key_rd_slot = 1'(slot);
        key_rd_addr = 7'(addr);
        e_v[0]   = 1'b1;
        e_err[0] = !m_valid[slot] || (addr >= m_t[slot]);
        e_dat[0] = e_err[0] ? 64'd0 : m_sched[slot][addr];
    endtask

    task automatic read_all(input int slot, input int n);
        for (int a = 0; a < n; a++) begin
            rd(slot, a);
            tick();
        end
        tick();
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1; key_start = 1'b0; key_rd_en = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin m_valid[s] = 1'b0; m_t[s] = 0; end
        for (int s = 0; s < 2; s++) begin e_v[s] = 1'b0; e_err[s] = 1'b0; e_dat[s] = '0; end
        last_data = '0;
        chk("rst_ready", obs_ready, 1);
        chk("rst_done", obs_done, 0);
        chk("rst_cfg_err", obs_cfg_err, 0);
        chk("rst_vld", obs_vld, 0);
        chk("rst_rd_err", obs_rd_err, 0);
        chk("rst_data", obs_data, 0);
        chk("rst_slot_valid", obs_slot_valid, 0);
        chk("rst_slot_rounds", obs_slot_rounds, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic expand(input int slot, input int mode, input logic [255:0] key,
                          input bit pingpong, input bit poke);
        int t, busy, d0, c0;
        bit done;
        build(sel32 ? 32 : 64, mode + 2, key, t);
        d0 = done_cnt; c0 = cfg_cnt;
        chk("ready_before_start", obs_ready, 1);
        key_start = 1'b1; key_mode = 2'(mode); key_slot = 1'(slot); init_key = key;
        if (pingpong) rd(1, 0);
        tick();
        key_start = 1'b0;
        m_valid[slot] = 1'b0;
        busy = 0; done = 1'b0;
        for (int j = 0; j < 200 && !done; j++) begin
            if (obs_done) begin
                done = 1'b1;
                chk("done_latency", j, t);
                chk("busy_cycles", busy, t);
                chk("ready_after_done", obs_ready, 1);
                m_valid[slot] = 1'b1;
                m_t[slot] = t;
                for (int a = 0; a < 128; a++) m_sched[slot][a] = exp_sched[a];
                chk("slot_valid_set", obs_slot_valid[slot], 1);
                chk("slot_rounds", obs_slot_rounds[slot*7 +: 7], t);
            end else begin
                if (!obs_ready) busy++;
                if (poke && j == 5) begin key_start = 1'b1; key_mode = 2'd3; key_slot = ~1'(slot); end
                if (poke && j == 7) key_start = 1'b0;
                if (pingpong) begin
                    if (j % 8 == 7)   rd(slot, j % t);
                    else if (m_t[1] > 0) rd(1, j % m_t[1]);
                end
            end
            tick();
        end
        chk("done_seen", done, 1);
        chk("done_pulse_end", obs_done, 0);
        chk("done_count", done_cnt - d0, 1);
        chk("no_cfg_err_when_busy", cfg_cnt - c0, 0);
    endtask

    task automatic illegal(input int mode, input int slot);
        int c0;
        c0 = cfg_cnt;
        key_start = 1'b1; key_mode = 2'(mode); key_slot = 1'(slot);
        tick();
        key_start = 1'b0;
        chk("cfg_err_pulse", obs_cfg_err, 1);
        chk("cfg_ready", obs_ready, 1);
        tick();
        chk("cfg_err_clear", obs_cfg_err, 0);
        chk("cfg_err_count", cfg_cnt - c0, 1);
        chk("cfg_slots_valid", obs_slot_valid, {m_valid[1], m_valid[0]});
        chk("cfg_slots_rounds", obs_slot_rounds, {7'(m_t[1]), 7'(m_t[0])});
    endtask

    function automatic logic [255:0] rkey();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        sel32 = 1'b0; key_start = 1'b0; key_mode = '0; key_slot = 1'b0; init_key = '0;
        key_rd_en = 1'b0; key_rd_slot = 1'b0; key_rd_addr = '0;
        apply_reset();

        // published 128/256 key, full readback incl. first out-of-range address
        expand(0, 2, TV_KEY, 1'b0, 1'b0);
        read_all(0, 73);
        rd(0, 127); tick(); tick(); tick();

        // m=2 / m=3 with z wrap; a busy-time start must be ignored
        expand(0, 0, rkey(), 1'b0, 1'b1);
        expand(1, 1, rkey(), 1'b0, 1'b0);
        read_all(0, 69);
        read_all(1, 70);

        illegal(3, 0);
        read_all(0, 3);

        // expand slot 0 while slot 1 is read every cycle
        expand(0, 2, rkey(), 1'b1, 1'b0);
        read_all(0, 73);

        // reset in the middle of an expansion, then a clean restart
        key_start = 1'b1; key_mode = 2'd1; key_slot = 1'b1; init_key = rkey();
        tick();
        key_start = 1'b0;
        m_valid[1] = 1'b0;
        repeat (20) tick();
        chk("busy_mid_run", obs_ready, 0);
        apply_reset();
        expand(1, 1, rkey(), 1'b0, 1'b0);
        read_all(1, 70);
        read_all(0, 2);

        // 32-bit build
        sel32 = 1'b1;
        apply_reset();
        expand(0, 1, rkey(), 1'b0, 1'b0);
        expand(1, 2, rkey(), 1'b0, 1'b0);
        illegal(0, 1);
        read_all(0, 43);
        read_all(1, 45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
